// File: rtl/dmem_unit_pkg.sv
// Shared types and constants for the data-side memory unit.
package dmem_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int ROB_W  = 4;

    // Memory opcodes presented by the load/store buffer.
    localparam logic [5:0] OP_LB  = 6'h01;
    localparam logic [5:0] OP_LH  = 6'h02;
    localparam logic [5:0] OP_LW  = 6'h03;
    localparam logic [5:0] OP_LBU = 6'h04;
    localparam logic [5:0] OP_LHU = 6'h05;
    localparam logic [5:0] OP_SB  = 6'h06;
    localparam logic [5:0] OP_SH  = 6'h07;
    localparam logic [5:0] OP_SW  = 6'h08;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_RD   = 2'd1,
        DM_WR   = 2'd2,
        DM_DONE = 2'd3
    } dm_state_t;

    // Request as latched at acceptance.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0][7:0]   val;
        logic [5:0]        op;
        logic [ROB_W-1:0]  tag;
    } dm_req_t;

    // Access size in bytes.
    function automatic logic [2:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
            default:              op_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        op_is_load = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                     (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/dmem_unit_if.sv
// Request/completion, RAM bus and data-CDB signals of the memory unit.
interface dmem_unit_if import dmem_unit_pkg::*; ();
    logic              LSB_sgn;
    logic [ADDR_W-1:0] LSB_addr;
    logic [31:0]       LSB_val;
    logic [5:0]        LSB_opcode;
    logic [ROB_W-1:0]  LSB_ROB_name;
    logic              LSB_done;
    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic [7:0]        mem_din;
    logic              CDBD_sgn;
    logic [31:0]       CDBD_result;
    logic [ROB_W-1:0]  CDBD_ROB_name;

    modport slave (
        input  LSB_sgn, LSB_addr, LSB_val, LSB_opcode, LSB_ROB_name,
        input  mem_gnt, mem_din,
        output LSB_done, mem_req, mem_a, mem_dout, mem_wr,
        output CDBD_sgn, CDBD_result, CDBD_ROB_name
    );

    modport master (
        output LSB_sgn, LSB_addr, LSB_val, LSB_opcode, LSB_ROB_name,
        output mem_gnt, mem_din,
        input  LSB_done, mem_req, mem_a, mem_dout, mem_wr,
        input  CDBD_sgn, CDBD_result, CDBD_ROB_name
    );
endinterface

// File: rtl/dmem_unit_load_extend.sv
// Size/sign extension of up to four little-endian load bytes.
module load_extend import dmem_unit_pkg::*; (
    input  logic [3:0][7:0] data,
    input  logic [5:0]      opcode,
    output logic [31:0]     result
);

    // Select width and fill by opcode; words pass through.
    always_comb begin
        result = data;
        case (opcode)
            OP_LB:   result = {{24{data[0][7]}}, data[0]};
            OP_LBU:  result = {24'd0, data[0]};
            OP_LH:   result = {{16{data[1][7]}}, data[1], data[0]};
            OP_LHU:  result = {16'd0, data[1], data[0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// Byte-serial load/store engine between the load/store buffer and the
// 8-bit RAM port; loads are broadcast on the data CDB.
module dmem_unit import dmem_unit_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       jp_wrong,
    dmem_unit_if.slave bus
);

    dm_state_t         state;
    logic [2:0]        cnt;
    dm_req_t           req_q;
    logic [3:0][7:0]   bytes_q;

    logic [2:0]        size;
    logic              is_load;
    logic              accept;
    logic              capture;
    logic [1:0]        cap_idx;
    logic [2:0]        byte_off;
    logic [ADDR_W-1:0] cur_a;
    logic              done_ok;
    logic [31:0]       ext_res;

    assign size    = op_size(req_q.op);
    assign is_load = op_is_load(req_q.op);
    assign accept  = (state == DM_IDLE) && rdy && bus.LSB_sgn && bus.mem_gnt && !jp_wrong;
    // Byte k arrives while counter reads k+1.
    assign capture = (state == DM_RD) && rdy && !jp_wrong && (cnt != 3'd0);
    assign cap_idx = cnt[1:0] - 2'd1;

    // While a load is stalled, keep the RAM pointed at the byte still owed
    // so the read data is valid again on the resume cycle.
    assign byte_off = ((state == DM_RD) && !rdy && (cnt != 3'd0)) ? cnt - 3'd1 : cnt;
    assign cur_a    = req_q.addr + {{(ADDR_W-3){1'b0}}, byte_off};

    // DONE may be blocked by a stall, or by a flush when the access is a load.
    assign done_ok = (state == DM_DONE) && rdy && !(is_load && jp_wrong);

    load_extend u_ext (
        .data   (bytes_q),
        .opcode (req_q.op),
        .result (ext_res)
    );

    // Control FSM: sequencing and byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DM_IDLE;
            cnt   <= 3'd0;
        end else if (rdy) begin
            case (state)
                DM_IDLE: begin
                    if (accept) begin
                        cnt   <= 3'd0;
                        state <= op_is_load(bus.LSB_opcode) ? DM_RD : DM_WR;
                    end
                end
                DM_RD: begin
                    if (jp_wrong)
                        state <= DM_IDLE;
                    else if (cnt == size)
                        state <= DM_DONE;
                    else
                        cnt <= cnt + 3'd1;
                end
                DM_WR: begin
                    // Stores are already committed; a flush does not stop them.
                    if (cnt == size - 3'd1)
                        state <= DM_DONE;
                    else
                        cnt <= cnt + 3'd1;
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

    // Request and load-byte registers; contents are don't-care out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q.addr <= bus.LSB_addr;
            req_q.val  <= bus.LSB_val;
            req_q.op   <= bus.LSB_opcode;
            req_q.tag  <= bus.LSB_ROB_name;
        end
        if (capture)
            bytes_q[cap_idx] <= bus.mem_din;
    end

    // Bus, completion and CDB outputs decoded from the current state.
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_a         = '0;
        bus.mem_dout      = 8'd0;
        bus.mem_wr        = 1'b0;
        bus.LSB_done      = done_ok;
        bus.CDBD_sgn      = done_ok && is_load;
        bus.CDBD_result   = 32'd0;
        bus.CDBD_ROB_name = '0;
        case (state)
            DM_IDLE: bus.mem_req = bus.LSB_sgn && !rst;
            DM_RD: begin
                bus.mem_req = 1'b1;
                if (byte_off < size)
                    bus.mem_a = cur_a;
            end
            DM_WR: begin
                bus.mem_req  = 1'b1;
                bus.mem_a    = cur_a;
                bus.mem_dout = req_q.val[cnt[1:0]];
                bus.mem_wr   = rdy;
            end
            default: ;
        endcase
        if (bus.CDBD_sgn) begin
            bus.CDBD_result   = ext_res;
            bus.CDBD_ROB_name = req_q.tag;
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboarded bench for dmem_unit with a one-cycle-latency byte RAM.
module tb_dmem_unit;
    import dmem_unit_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, jp_wrong;

    dmem_unit_if bus();

    dmem_unit dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .jp_wrong (jp_wrong),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];

    // RAM: read data one cycle after its address; byte writes.
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[11:0]];
        if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end

    // Arbiter always grants.
    assign bus.mem_gnt = bus.mem_req;

    typedef struct { logic [ROB_W-1:0] tag; logic [31:0] res; } cdb_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    cdb_t cdb_q[$];
    wr_t  wr_q[$];
    cdb_t mon_c;
    wr_t  mon_w;

    int n_vec = 0, n_err = 0, done_cnt = 0, done_exp = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int sz(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ld_model(input logic [5:0] op, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ram[a[11:0]];
        b1 = ram[a[11:0] + 12'd1];
        b2 = ram[a[11:0] + 12'd2];
        b3 = ram[a[11:0] + 12'd3];
        case (op)
            OP_LB:   return {{24{b0[7]}}, b0};
            OP_LBU:  return {24'd0, b0};
            OP_LH:   return {{16{b1[7]}}, b1, b0};
            OP_LHU:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Scoreboard monitor: every CDB broadcast and RAM write must be expected.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.CDBD_sgn) begin
                if (cdb_q.size() == 0) chk("cdb_spurious", bus.CDBD_sgn, 1'b0);
                else begin
                    mon_c = cdb_q.pop_front();
                    chk("cdb_tag", bus.CDBD_ROB_name, mon_c.tag);
                    chk("cdb_res", bus.CDBD_result, mon_c.res);
                end
            end
            if (bus.mem_wr) begin
                if (wr_q.size() == 0) chk("wr_spurious", bus.mem_wr, 1'b0);
                else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", bus.mem_a, mon_w.a);
                    chk("wr_data", bus.mem_dout, mon_w.d);
                end
            end
            if (bus.LSB_done) done_cnt++;
        end
    end

    // One request: push expectations, hold LSB_sgn until done (or timeout),
    // optionally flush at cycle jp_at or stall 3 cycles from cycle stall_at.
    task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] v,
                       input logic [ROB_W-1:0] tag, input int jp_at, input int stall_at,
                       input bit exp_done);
        int n, lat, lat_exp;
        bit ld, seen;
        ld = (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
        n = sz(op);
        lat_exp = (ld ? n + 2 : n + 1) + (stall_at != 0 ? 3 : 0);
        if (ld && exp_done) cdb_q.push_back('{tag, ld_model(op, a)});
        if (!ld) for (int k = 0; k < n; k++) wr_q.push_back('{a + 32'(k), v[8*k +: 8]});
        if (exp_done) done_exp++;
        bus.LSB_sgn = 1'b1;
        bus.LSB_addr = a;
        bus.LSB_val = v;
        bus.LSB_opcode = op;
        bus.LSB_ROB_name = tag;
        seen = 1'b0;
        lat = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ld && stall_at == 0 && jp_at == 0 && i <= n) begin
                chk("rd_addr", bus.mem_a, a + 32'(i) - 32'd1);
                chk("rd_req", bus.mem_req, 1'b1);
                chk("rd_nowr", bus.mem_wr, 1'b0);
            end
            if (!exp_done && i == jp_at + 1) chk("abort_idle_a", bus.mem_a, 32'd0);
            if (bus.LSB_done) begin
                seen = 1'b1;
                lat = i;
            end
            if (i == jp_at) jp_wrong = 1'b1;
            if (stall_at != 0 && i == stall_at) rdy = 1'b0;
            if (stall_at != 0 && i == stall_at + 3) rdy = 1'b1;
        end
        chk("done_seen", seen, exp_done);
        if (exp_done) chk("latency", lat, lat_exp);
        @(posedge clk);
        #1;
        bus.LSB_sgn = 1'b0;
        jp_wrong = 1'b0;
        chk("done_count", done_cnt, done_exp);
    endtask

    logic [7:0] pre;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0;
        bus.LSB_sgn = 1'b0; bus.LSB_addr = '0; bus.LSB_val = '0;
        bus.LSB_opcode = '0; bus.LSB_ROB_name = '0;
        for (int i = 0; i < 4096; i++) ram[i] = i[7:0] ^ 8'h5A;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'h110] = 8'h80;
        ram[12'h120] = 8'h01; ram[12'h121] = 8'h80;

        repeat (2) @(negedge clk);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_wr", bus.mem_wr, 1'b0);
        chk("rst_a", bus.mem_a, 32'd0);
        chk("rst_dout", bus.mem_dout, 8'd0);
        chk("rst_done", bus.LSB_done, 1'b0);
        chk("rst_cdb", bus.CDBD_sgn, 1'b0);
        chk("rst_res", bus.CDBD_result, 32'd0);
        chk("rst_tag", bus.CDBD_ROB_name, '0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);

        // Plain loads of every flavour.
        run(OP_LW,  32'h100, 32'h0, 4'd5, 0, 0, 1'b1);
        run(OP_LB,  32'h110, 32'h0, 4'd1, 0, 0, 1'b1);
        run(OP_LBU, 32'h110, 32'h0, 4'd2, 0, 0, 1'b1);
        run(OP_LH,  32'h120, 32'h0, 4'd3, 0, 0, 1'b1);

        // Halfword store leaves the third byte alone.
        pre = ram[12'h202];
        run(OP_SH, 32'h200, 32'hDEADBEEF, 4'd0, 0, 0, 1'b1);
        chk("sh_b0", ram[12'h200], 8'hEF);
        chk("sh_b1", ram[12'h201], 8'hBE);
        chk("sh_202_kept", ram[12'h202], pre);

        // Back-to-back with LSB_sgn effectively held across done.
        run(OP_SW,  32'h210, 32'h01020304, 4'd0, 0, 0, 1'b1);
        run(OP_LHU, 32'h120, 32'h0, 4'd4, 0, 0, 1'b1);
        run(OP_SB,  32'h214, 32'h000000A5, 4'd0, 0, 0, 1'b1);

        // Flush during load byte 2, then flush during a store.
        run(OP_LW, 32'h100, 32'h0, 4'd6, 3, 0, 1'b0);
        run(OP_SW, 32'h220, 32'hCAFEF00D, 4'd0, 2, 0, 1'b1);
        chk("sw_jp_b3", ram[12'h223], 8'hCA);

        // Three-cycle stall inside a word load.
        run(OP_LW, 32'h100, 32'h0, 4'd7, 0, 2, 1'b1);

        // Reset after two bytes of a word store.
        wr_q.push_back('{32'h230, 8'h78});
        wr_q.push_back('{32'h231, 8'h56});
        pre = ram[12'h232];
        bus.LSB_sgn = 1'b1; bus.LSB_addr = 32'h230; bus.LSB_val = 32'h12345678;
        bus.LSB_opcode = OP_SW;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; bus.LSB_sgn = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", bus.mem_req, 1'b0);
        chk("mid_rst_wr", bus.mem_wr, 1'b0);
        chk("mid_rst_a", bus.mem_a, 32'd0);
        chk("mid_rst_dout", bus.mem_dout, 8'd0);
        chk("mid_rst_done", bus.LSB_done, 1'b0);
        chk("mid_rst_cdb", bus.CDBD_sgn, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_wr", bus.mem_wr, 1'b0);
        end
        chk("rst_partial_b1", ram[12'h231], 8'h56);
        chk("rst_partial_b2", ram[12'h232], pre);

        // Unit recovers after reset.
        run(OP_LW, 32'h100, 32'h0, 4'd9, 0, 0, 1'b1);

        repeat (3) @(negedge clk);
        chk("cdb_q_left", cdb_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);
        chk("done_total", done_cnt, done_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
